// File: rtl/mips_inst_encoder_if.sv
// Request and IMEM-write bundle for mips_inst_encoder.
//   master : request source / IMEM sink side (drives in_*, im_ready)
//   slave  : the encoder (drives in_ready, im_we, im_addr, im_wdata)
// Signals:
//   in_valid/in_ready          request handshake
//   in_mnem                    mnemonic index 0..53
//   in_rs/in_rt/in_rd/in_shamt register and shift fields
//   in_imm, in_target          immediate and jump target fields
//   im_we/im_ready             IMEM write handshake
//   im_addr, im_wdata          IMEM word address and encoded word
interface mips_inst_encoder_if #(
   parameter int AW = 11
) ();
   logic          in_valid;
   logic          in_ready;
   logic [5:0]    in_mnem;
   logic [4:0]    in_rs;
   logic [4:0]    in_rt;
   logic [4:0]    in_rd;
   logic [4:0]    in_shamt;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic          im_ready;

   modport master (
      output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      output im_ready,
      input  in_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      input  im_ready,
      output in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/mips_inst_encoder.sv
// Sequential MIPS instruction encoder/loader. Takes symbolic instruction
// requests, encodes each to a 32-bit MIPS32 word and writes the words to
// consecutive IMEM addresses starting at a base address given with start.
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   start        1-cycle pulse, begins a session at base_addr
//   base_addr    first word address of the session
//   bus          request + IMEM write bundle (slave side)
//   illegal      1-cycle pulse after an accepted out-of-range mnemonic
//   full         session capacity (DEPTH words) reached
//   word_count   words written in the current session
//
// state  | meaning
// S_IDLE | no session yet, requests not accepted
// S_RUN  | session open, requests accepted while capacity remains
// S_FULL | DEPTH words written, requests stall until next start
module mips_inst_encoder #(
   parameter int AW    = 11,
   parameter int DEPTH = 2048
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [AW-1:0]       base_addr,
   mips_inst_encoder_if.slave  bus,
   output logic                illegal,
   output logic                full,
   output logic [AW:0]         word_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

   state_t        state, state_nxt;
   logic [AW-1:0] ptr;
   logic          accept;
   logic          legal;
   logic          wr_done;
   logic [31:0]   enc;
   logic [AW:0]   wc_nxt;
   logic [AW+1:0] wc_pend;

   function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   assign wr_done = bus.im_we && bus.im_ready;
   assign accept  = bus.in_valid && bus.in_ready;
   assign wc_nxt  = word_count + {{AW{1'b0}}, wr_done};
   // words written plus the one in flight; a new request needs room beyond both
   assign wc_pend = {1'b0, word_count} + {{(AW+1){1'b0}}, bus.im_we};

   always_comb begin
      enc   = 32'd0;
      legal = 1'b1;
      case (bus.in_mnem)
         6'd0:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20);
         6'd1:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21);
         6'd2:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22);
         6'd3:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h23);
         6'd4:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24);
         6'd5:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25);
         6'd6:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h26);
         6'd7:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h27);
         6'd8:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2A);
         6'd9:  enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h2B);
         6'd10: enc = r_fmt(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00);
         6'd11: enc = r_fmt(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h02);
         6'd12: enc = r_fmt(5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h03);
         6'd13: enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h04);
         6'd14: enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h06);
         6'd15: enc = r_fmt(bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h07);
         6'd16: enc = r_fmt(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h08);
         6'd17: enc = i_fmt(6'h08, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd18: enc = i_fmt(6'h09, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd19: enc = i_fmt(6'h0C, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd20: enc = i_fmt(6'h0D, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd21: enc = i_fmt(6'h0E, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd22: enc = i_fmt(6'h0F, 5'd0, bus.in_rt, bus.in_imm);
         6'd23: enc = i_fmt(6'h23, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd24: enc = i_fmt(6'h2B, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd25: enc = i_fmt(6'h04, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd26: enc = i_fmt(6'h05, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd27: enc = i_fmt(6'h0A, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd28: enc = i_fmt(6'h0B, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd29: enc = {6'h02, bus.in_target};
         6'd30: enc = {6'h03, bus.in_target};
         6'd31: enc = r_fmt(bus.in_rs, bus.in_rt, 5'd0, 5'd0, 6'h1A);
         6'd32: enc = r_fmt(bus.in_rs, bus.in_rt, 5'd0, 5'd0, 6'h1B);
         6'd33: enc = r_fmt(bus.in_rs, bus.in_rt, 5'd0, 5'd0, 6'h18);
         6'd34: enc = r_fmt(bus.in_rs, bus.in_rt, 5'd0, 5'd0, 6'h19);
         6'd35: enc = i_fmt(6'h01, bus.in_rs, 5'd1, bus.in_imm);
         6'd36: enc = r_fmt(bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h09);
         6'd37: enc = i_fmt(6'h24, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd38: enc = i_fmt(6'h25, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd39: enc = i_fmt(6'h20, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd40: enc = i_fmt(6'h21, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd41: enc = i_fmt(6'h28, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd42: enc = i_fmt(6'h29, bus.in_rs, bus.in_rt, bus.in_imm);
         6'd43: enc = 32'h0000_000D;
         6'd44: enc = 32'h0000_000C;
         6'd45: enc = 32'h4200_0018;
         6'd46: enc = r_fmt(bus.in_rs, bus.in_rt, 5'd0, 5'd0, 6'h34);
         6'd47: enc = r_fmt(5'd0, 5'd0, bus.in_rd, 5'd0, 6'h10);
         6'd48: enc = r_fmt(5'd0, 5'd0, bus.in_rd, 5'd0, 6'h12);
         6'd49: enc = r_fmt(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h11);
         6'd50: enc = r_fmt(bus.in_rs, 5'd0, 5'd0, 5'd0, 6'h13);
         6'd51: enc = {6'h10, 5'd0, bus.in_rt, bus.in_rd, 11'd0};
         // core decoder keys MTC0 on funct 000100 as well as the rs=00100 field
         6'd52: enc = {6'h10, 5'd4, bus.in_rt, bus.in_rd, 5'd0, 6'h04};
         6'd53: enc = {6'h1C, bus.in_rs, 5'd0, bus.in_rd, 5'd0, 6'h20};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_RUN;
      end else begin
         case (state)
            S_RUN:   if ({1'b0, wc_nxt} == DEPTH_W) state_nxt = S_FULL;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      bus.in_ready = (state == S_RUN) && !start && (!bus.im_we || bus.im_ready) &&
                     (wc_pend < DEPTH_W);
      full         = (state == S_FULL);
   end

   // ptr is the address the next accepted word will use; it runs one ahead
   // of the completed-write count while a word is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr          <= '0;
         word_count   <= '0;
         illegal      <= 1'b0;
         bus.im_we    <= 1'b0;
         bus.im_addr  <= '0;
         bus.im_wdata <= 32'd0;
      end else begin
         illegal <= accept && !legal;
         if (start) begin
            ptr        <= base_addr;
            word_count <= '0;
            bus.im_we  <= 1'b0;
         end else begin
            word_count <= wc_nxt;
            if (accept && legal) begin
               bus.im_we    <= 1'b1;
               bus.im_addr  <= ptr;
               bus.im_wdata <= enc;
               ptr          <= ptr + 1'b1;
            end else if (wr_done) begin
               bus.im_we <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_inst_encoder.sv
module tb_mips_inst_encoder;
   localparam int AW    = 11;
   localparam int DEPTH = 4;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          illegal;
   logic          full;
   logic [AW:0]   word_count;

   mips_inst_encoder_if #(.AW(AW)) bus ();

   mips_inst_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .bus(bus.slave), .illegal(illegal), .full(full), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_writes = 0;
   wr_t           sb[$];
   logic [AW-1:0] exp_ptr = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Reference encoder built from field-usage flags.
   function automatic logic [31:0] ref_enc(input logic [5:0] m, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tgt);
      logic [5:0]  op, fn;
      logic        urs, urt, urd, ush, ity;
      logic [31:0] w;
      op = 6'd0; fn = 6'd0; urs = 0; urt = 0; urd = 0; ush = 0; ity = 0;
      case (m)
         0, 1, 2, 3, 4, 5, 6, 7: begin fn = 6'h20 + m; urs = 1; urt = 1; urd = 1; end
         8, 9:         begin fn = 6'h2A + (m - 6'd8); urs = 1; urt = 1; urd = 1; end
         10, 11, 12:   begin fn = (m == 6'd10) ? 6'd0 : m - 6'd9; urt = 1; urd = 1; ush = 1; end
         13, 14, 15:   begin fn = (m == 6'd13) ? 6'd4 : m - 6'd8; urs = 1; urt = 1; urd = 1; end
         16:           begin fn = 6'h08; urs = 1; end
         36:           begin fn = 6'h09; urs = 1; urd = 1; end
         31:           begin fn = 6'h1A; urs = 1; urt = 1; end
         32:           begin fn = 6'h1B; urs = 1; urt = 1; end
         33:           begin fn = 6'h18; urs = 1; urt = 1; end
         34:           begin fn = 6'h19; urs = 1; urt = 1; end
         46:           begin fn = 6'h34; urs = 1; urt = 1; end
         47:           begin fn = 6'h10; urd = 1; end
         48:           begin fn = 6'h12; urd = 1; end
         49:           begin fn = 6'h11; urs = 1; end
         50:           begin fn = 6'h13; urs = 1; end
         17: begin op = 6'h08; ity = 1; end
         18: begin op = 6'h09; ity = 1; end
         19: begin op = 6'h0C; ity = 1; end
         20: begin op = 6'h0D; ity = 1; end
         21: begin op = 6'h0E; ity = 1; end
         22: begin op = 6'h0F; ity = 1; end
         23: begin op = 6'h23; ity = 1; end
         24: begin op = 6'h2B; ity = 1; end
         25: begin op = 6'h04; ity = 1; end
         26: begin op = 6'h05; ity = 1; end
         27: begin op = 6'h0A; ity = 1; end
         28: begin op = 6'h0B; ity = 1; end
         37: begin op = 6'h24; ity = 1; end
         38: begin op = 6'h25; ity = 1; end
         39: begin op = 6'h20; ity = 1; end
         40: begin op = 6'h21; ity = 1; end
         41: begin op = 6'h28; ity = 1; end
         42: begin op = 6'h29; ity = 1; end
         29: return {6'h02, tgt};
         30: return {6'h03, tgt};
         35: return {6'h01, rs, 5'd1, imm};
         43: return 32'h0000_000D;
         44: return 32'h0000_000C;
         45: return 32'h4200_0018;
         51: return {6'h10, 5'd0, rt, rd, 11'd0};
         52: return {6'h10, 5'd4, rt, rd, 5'd0, 6'h04};
         53: return {6'h1C, rs, 5'd0, rd, 5'd0, 6'h20};
         default: return 32'd0;
      endcase
      if (ity) begin
         urs = (m != 6'd22);
         urt = 1;
      end
      w = {op, urs ? rs : 5'd0, urt ? rt : 5'd0, urd ? rd : 5'd0, ush ? sh : 5'd0, fn};
      if (ity) w[15:0] = imm;
      return w;
   endfunction

   // Scoreboard: a write is seen when im_we && im_ready just before an edge.
   always begin : mon
      wr_t e;
      @(negedge clk);
      #2;
      if (rst_n && !start && bus.im_we && bus.im_ready) begin
         n_writes++;
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("im_addr", 32'(bus.im_addr), 32'(e.a));
            chk("im_wdata", bus.im_wdata, e.d);
         end
      end
   end

   task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp_w, input int maxc,
                       output bit acc);
      acc = 0;
      @(negedge clk);
      bus.in_mnem = m; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt;
      bus.in_valid = 1'b1;
      for (int k = 0; k < maxc; k++) begin
         #2;
         if (bus.in_ready) begin
            @(posedge clk);
            acc = 1;
            break;
         end
         @(negedge clk);
      end
      if (acc && m < 6'd54) begin
         sb.push_back('{exp_ptr, exp_w});
         exp_ptr++;
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic req(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] exp_w);
      bit acc;
      send(m, rs, rt, rd, sh, imm, tgt, exp_w, 20, acc);
      chk("accept", 32'(acc), 32'd1);
   endtask

   task automatic req_model(input logic [5:0] m);
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] tgt;
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
      imm = 16'($urandom); tgt = 26'($urandom);
      req(m, rs, rt, rd, sh, imm, tgt, ref_enc(m, rs, rt, rd, sh, imm, tgt));
   endtask

   task automatic do_start(input logic [AW-1:0] base);
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      sb.delete();
      exp_ptr = base;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #3;
         if (sb.size() == 0 && !bus.im_we) break;
      end
      chk("drain", 32'(sb.size()) + 32'(bus.im_we), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
      chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
      chk({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
      chk({tag, "_illegal"}, 32'(illegal), 32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bit            acc;
      int            w0;
      logic [31:0]   hold_d;
      bus.in_valid = 0; bus.in_mnem = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
      bus.in_shamt = 0; bus.in_imm = 0; bus.in_target = 0; bus.im_ready = 1'b1;

      repeat (2) @(negedge clk);
      #2 chk_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #2 chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // ADDU with a stray shamt
      do_start(11'h010);
      #2 chk("run_in_ready", 32'(bus.in_ready), 32'd1);
      req(6'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'hFFFF, 26'h3FFFFFF, 32'h0022_1821);
      drain();
      chk("t1_word_count", 32'(word_count), 32'd1);

      // LUI (stray rs) and J back-to-back
      req(6'd22, 5'd5, 5'd8, 5'd9, 5'd3, 16'h1234, 26'd0, 32'h3C08_1234);
      req(6'd29, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h010_0000, 32'h0810_0000);
      drain();
      chk("t2_word_count", 32'(word_count), 32'd3);

      // system/coprocessor encodings with stray fields
      do_start(11'h020);
      req(6'd52, 5'd7, 5'd5, 5'd12, 5'd9, 16'hABCD, 26'h1555555, 32'h4085_6004);
      req(6'd45, 5'd3, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h2AAAAAA, 32'h4200_0018);
      req(6'd44, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000_000C);
      drain();
      chk("t3_word_count", 32'(word_count), 32'd3);

      // every mnemonic with random stray fields, four per session
      for (int m = 0; m < 54; m++) begin
         if (m % 4 == 0) begin
            drain();
            do_start(11'(m * 8));
         end
         req_model(6'(m));
      end
      drain();

      // IMEM back-pressure
      do_start(11'h030);
      @(negedge clk);
      bus.im_ready = 1'b0;
      w0 = n_writes;
      hold_d = ref_enc(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0);
      req(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0, hold_d);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #2;
         chk("hold_im_we", 32'(bus.im_we), 32'd1);
         chk("hold_im_addr", 32'(bus.im_addr), 32'h030);
         chk("hold_im_wdata", bus.im_wdata, hold_d);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.im_ready = 1'b1;
      drain();
      chk("hold_writes", 32'(n_writes - w0), 32'd1);
      chk("hold_word_count", 32'(word_count), 32'd1);

      // address wrap and capacity
      do_start(11'h7FE);
      for (int i = 0; i < 4; i++) req_model(6'(17 + i));
      drain();
      chk("wrap_full", 32'(full), 32'd1);
      chk("wrap_word_count", 32'(word_count), 32'd4);
      chk("wrap_ptr", 32'(exp_ptr), 32'h002);
      send(6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0,
           ref_enc(6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0), 5, acc);
      chk("full_stall", 32'(acc), 32'd0);
      do_start(11'h100);
      #2 chk("restart_full", 32'(full), 32'd0);
      req_model(6'd5);
      req_model(6'd6);
      drain();
      chk("restart_word_count", 32'(word_count), 32'd2);

      // illegal mnemonic
      w0 = n_writes;
      send(6'd54, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6, 32'd0, 20, acc);
      chk("illegal_accept", 32'(acc), 32'd1);
      @(negedge clk);
      #2;
      chk("illegal_pulse", 32'(illegal), 32'd1);
      chk("illegal_no_we", 32'(bus.im_we), 32'd0);
      @(negedge clk);
      #2;
      chk("illegal_clear", 32'(illegal), 32'd0);
      chk("illegal_word_count", 32'(word_count), 32'd2);
      chk("illegal_writes", 32'(n_writes - w0), 32'd0);

      // reset while a word is pending
      @(negedge clk);
      bus.im_ready = 1'b0;
      req_model(6'd7);
      @(negedge clk);
      #2 chk("pre_rst_im_we", 32'(bus.im_we), 32'd1);
      w0 = n_writes;
      rst_n = 1'b0;
      sb.delete();
      #1 chk_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.im_ready = 1'b1;
      @(negedge clk);
      #3 chk("midrst_writes", 32'(n_writes - w0), 32'd0);
      do_start(11'h040);
      req_model(6'd53);
      drain();
      chk("post_rst_word_count", 32'(word_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
